// File: rtl/alu_seq.sv
// Sequenced ALU: single-cycle logic/arithmetic ops plus an iterative shift-add
// multiplier, with a valid/ready handshake on both the operand and result sides.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for a new operation (subject to result back-pressure)
//   MUL   | shift-add multiply in progress, one multiplier bit per cycle
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       S,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] Q,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             Busy
);

    localparam int         MSB    = WIDTH - 1;
    localparam int         CW     = $clog2(WIDTH + 1);
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]     mplier_q;

    logic [WIDTH-1:0]     q_q;
    logic                 z_q, n_q, c_q, v_q;
    logic                 out_valid_q;

    logic                 accept;
    logic                 mul_done;

    logic [WIDTH:0]       sum_ext, diff_ext, inc_ext;
    logic [WIDTH-1:0]     alu_r;
    logic                 alu_c, alu_v;

    assign InReady  = (state_q == IDLE) && (!out_valid_q || OutReady);
    assign accept   = InValid && InReady;
    assign mul_done = (state_q == MUL) && (cnt_q == CW'(1));
    assign Busy     = (state_q == MUL);
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign Q        = q_q;
    assign Z        = z_q;
    assign N        = n_q;
    assign C        = c_q;
    assign V        = v_q;
    assign OutValid = out_valid_q;

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: multiply entered on accept, left on the product-writing edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && (S == OP_MUL)) state_d = MUL;
            MUL:  if (mul_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle datapath; result and carry/overflow per opcode
    always_comb begin
        sum_ext  = {1'b0, A} + {1'b0, B};
        diff_ext = {1'b0, A} - {1'b0, B};
        inc_ext  = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
        alu_r    = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        case (S)
            4'd1: begin
                alu_r = sum_ext[MSB:0];
                alu_c = sum_ext[WIDTH];
                alu_v = (A[MSB] == B[MSB]) && (alu_r[MSB] != A[MSB]);
            end
            4'd2: begin
                alu_r = diff_ext[MSB:0];
                alu_c = diff_ext[WIDTH];
                alu_v = (A[MSB] != B[MSB]) && (alu_r[MSB] != A[MSB]);
            end
            4'd3: alu_r = A;
            4'd4: alu_r = A ^ B;
            4'd5: alu_r = A | B;
            4'd6: alu_r = A & B;
            4'd7: begin
                alu_r = inc_ext[MSB:0];
                alu_c = inc_ext[WIDTH];
                alu_v = alu_r[MSB] && !A[MSB];
            end
            4'd9: begin
                alu_r = {A[MSB-1:0], 1'b0};
                alu_c = A[MSB];
            end
            4'd10: begin
                alu_r = {1'b0, A[MSB:1]};
                alu_c = A[0];
            end
            default: ;
        endcase
    end

    // Multiplier: load on accept, then one shift-add step per cycle with a down-counter
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (accept && (S == OP_MUL)) begin
            mcand_q  <= {{WIDTH{1'b0}}, A};
            mplier_q <= B;
            acc_q    <= '0;
            cnt_q    <= CW'(WIDTH);
        end else if (state_q == MUL) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_step;
            cnt_q    <= cnt_q - CW'(1);
        end
    end

    // Result register; the final multiply step is written straight from acc_step
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            q_q         <= '0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept && (S != OP_MUL)) begin
            q_q         <= alu_r;
            z_q         <= (alu_r == '0);
            n_q         <= alu_r[MSB];
            c_q         <= alu_c;
            v_q         <= alu_v;
            out_valid_q <= 1'b1;
        end else if (mul_done) begin
            q_q         <= acc_step[MSB:0];
            z_q         <= (acc_step[MSB:0] == '0);
            n_q         <= acc_step[MSB];
            c_q         <= |acc_step[2*WIDTH-1:WIDTH];
            v_q         <= 1'b0;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && OutReady) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with hand-computed expected results.
module tb_alu_seq;

    logic        Clock;
    logic        Resetn;
    logic [15:0] A, B;
    logic [3:0]  S;
    logic        InValid, InReady;
    logic [15:0] Q;
    logic        Z, N, C, V;
    logic        OutValid, OutReady, Busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.WIDTH(16)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .A        (A),
        .B        (B),
        .S        (S),
        .InValid  (InValid),
        .InReady  (InReady),
        .Q        (Q),
        .Z        (Z),
        .N        (N),
        .C        (C),
        .V        (V),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Busy     (Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected result: OutValid, Q and flags packed {Z,N,C,V}
    task automatic expect_res(input string tag, input logic [15:0] q, input logic [3:0] zncv);
        check({tag, ".valid"}, {31'd0, OutValid}, 32'd1);
        check({tag, ".q"}, {16'd0, Q}, {16'd0, q});
        check({tag, ".zncv"}, {28'd0, Z, N, C, V}, {28'd0, zncv});
    endtask

    // Present one operation and return #1 after the accepting edge
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s);
        @(negedge Clock);
        A = a; B = b; S = s; InValid = 1'b1;
        @(posedge Clock);
        #1;
        InValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic busy_ok;
        logic seen_ov;

        Resetn = 1'b0; A = '0; B = '0; S = '0; InValid = 1'b0; OutReady = 1'b1;
        #1;
        check("reset.q", {16'd0, Q}, 32'd0);
        check("reset.flags", {27'd0, OutValid, Z, N, C, V}, 32'd0);
        check("reset.busy", {31'd0, Busy}, 32'd0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        #1;
        check("reset.inready", {31'd0, InReady}, 32'd1);

        issue(16'h7FFF, 16'h0001, 4'd1); expect_res("add",  16'h8000, 4'b0101);
        issue(16'h0003, 16'h0005, 4'd2); expect_res("sub",  16'hFFFE, 4'b0110);
        issue(16'hFFFF, 16'h0000, 4'd7); expect_res("inc",  16'h0000, 4'b1010);
        issue(16'h8001, 16'h0000, 4'd9); expect_res("shl",  16'h0002, 4'b0010);
        issue(16'h0003, 16'h0000, 4'd10); expect_res("shr", 16'h0001, 4'b0010);
        issue(16'hF0F0, 16'h0FF0, 4'd5); expect_res("or",   16'hFFF0, 4'b0100);
        issue(16'hF0F0, 16'h0FF0, 4'd6); expect_res("and",  16'h00F0, 4'b0000);
        issue(16'hFFFF, 16'hFFFF, 4'd0); expect_res("zero", 16'h0000, 4'b1000);
        issue(16'hF0F0, 16'h1234, 4'd3); expect_res("pass", 16'hF0F0, 4'b0100);
        issue(16'hFFFF, 16'hFFFF, 4'd13); expect_res("op13", 16'h0000, 4'b1000);

        // Multiply 300*300 = 0x15F90; a competing op is held on the input throughout
        issue(16'd300, 16'd300, 4'd8);
        OutReady = 1'b0;
        A = 16'h0001; B = 16'h0001; S = 4'd1; InValid = 1'b1;
        n = 0; busy_ok = 1'b1;
        while (!OutValid && n < 40) begin
            if (!(Busy && !InReady)) busy_ok = 1'b0;
            @(posedge Clock);
            #1;
            n++;
        end
        InValid = 1'b0;
        check("mul.latency", n, 32'd16);
        check("mul.busy_inready", {31'd0, busy_ok}, 32'd1);
        expect_res("mul", 16'h5F90, 4'b0010);
        check("mul.busy_after", {31'd0, Busy}, 32'd0);
        @(posedge Clock);
        #1;
        expect_res("mul.hold", 16'h5F90, 4'b0010);

        // Drain, then back-pressure with a pending XOR on the input
        @(negedge Clock);
        OutReady = 1'b1;
        @(posedge Clock);
        #1;
        check("drain.valid", {31'd0, OutValid}, 32'd0);
        OutReady = 1'b0;
        issue(16'h0001, 16'h0002, 4'd1); expect_res("bp.add", 16'h0003, 4'b0000);
        A = 16'hF0F0; B = 16'hFFFF; S = 4'd4; InValid = 1'b1;
        repeat (3) begin
            @(negedge Clock);
            check("bp.q_hold", {16'd0, Q}, 32'h0003);
            check("bp.inready", {31'd0, InReady}, 32'd0);
        end
        @(negedge Clock);
        OutReady = 1'b1;
        #1;
        check("bp.inready_drain", {31'd0, InReady}, 32'd1);
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        expect_res("bp.xor", 16'h0F0F, 4'b0000);
        @(posedge Clock);
        #1;
        check("bp.cleared", {31'd0, OutValid}, 32'd0);

        // Reset in the 5th busy cycle of a multiply
        issue(16'd300, 16'd300, 4'd8);
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("rst.busy_before", {31'd0, Busy}, 32'd1);
        Resetn = 1'b0;
        #1;
        check("rst.q", {16'd0, Q}, 32'd0);
        check("rst.flags", {27'd0, OutValid, Z, N, C, V}, 32'd0);
        check("rst.busy", {31'd0, Busy}, 32'd0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        #1;
        check("rst.inready", {31'd0, InReady}, 32'd1);
        seen_ov = 1'b0;
        repeat (24) begin
            @(posedge Clock);
            #1;
            if (OutValid || Busy) seen_ov = 1'b1;
        end
        check("rst.no_result", {31'd0, seen_ov}, 32'd0);

        issue(16'h0005, 16'h0006, 4'd1); expect_res("post_rst.add", 16'h000B, 4'b0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
